// File: rtl/serial_param_rx.sv
// 8N1 UART receiver feeding a 7-byte parameter-packet parser (A5, ADDR, D3..D0, CHK).
// Accepted packets produce a one-cycle register-write strobe; rejects raise sticky error flags.
module serial_param_rx #(
  parameter int CLKS_PER_BIT = 50,
  parameter int TIMEOUT_BITS = 256
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        RS232_Rx,
  input  logic        err_clr,
  output logic [3:0]  param_addr,
  output logic [31:0] param_data,
  output logic        param_we,
  output logic        frame_err,
  output logic        cmd_err,
  output logic [3:0]  dbg_state_o
);

  localparam int CNT_W     = $clog2(CLKS_PER_BIT);
  localparam int TMO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TMO_W     = $clog2(TMO_LIMIT + 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [TMO_W-1:0] TMO_M1  = TMO_W'(TMO_LIMIT - 1);

  localparam logic [1:0] U_IDLE  = 2'd0;
  localparam logic [1:0] U_START = 2'd1;
  localparam logic [1:0] U_DATA  = 2'd2;
  localparam logic [1:0] U_STOP  = 2'd3;

  localparam logic [1:0] P_HDR  = 2'd0;
  localparam logic [1:0] P_ADDR = 2'd1;
  localparam logic [1:0] P_DATA = 2'd2;
  localparam logic [1:0] P_CHK  = 2'd3;

  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  logic [1:0]       u_state_q, u_state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_valid_q, byte_valid_d;
  logic [7:0]       byte_q, byte_d;
  logic [1:0]       p_state_q, p_state_d;
  logic [1:0]       dcnt_q, dcnt_d;
  logic [3:0]       addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic [7:0]       chk_q, chk_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [3:0]       param_addr_q, param_addr_d;
  logic [31:0]      param_data_q, param_data_d;
  logic             param_we_q, param_we_d;
  logic             frame_err_q, frame_err_d;
  logic             cmd_err_q, cmd_err_d;

  logic start_edge, frame_set, stop_bad, cmd_set, tmo_run;

  assign start_edge = rx_prev_q & ~rx_sync_q & (u_state_q == U_IDLE);
  assign tmo_run    = (p_state_q != P_HDR) && (u_state_q == U_IDLE) && !start_edge;

  // UART bit-level FSM: mid-bit sampling referenced to the detected start edge.
  always_comb begin
    u_state_d    = u_state_q;
    clk_cnt_d    = clk_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    byte_d       = byte_q;
    frame_set    = 1'b0;
    stop_bad     = 1'b0;
    case (u_state_q)
      U_IDLE: begin
        if (start_edge) begin
          u_state_d = U_START;
          clk_cnt_d = '0;
        end
      end
      U_START: begin
        if (clk_cnt_q == HALF_M1) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          if (rx_sync_q) begin
            frame_set = 1'b1;
            u_state_d = U_IDLE;
          end else begin
            u_state_d = U_DATA;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      U_DATA: begin
        if (clk_cnt_q == FULL_M1) begin
          clk_cnt_d = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) u_state_d = U_STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        if (clk_cnt_q == FULL_M1) begin
          clk_cnt_d = '0;
          u_state_d = U_IDLE;
          if (rx_sync_q) begin
            byte_valid_d = 1'b1;
            byte_d       = shift_q;
          end else begin
            frame_set = 1'b1;
            stop_bad  = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  // Packet parser; a bad stop bit outranks everything and forces resync on the header.
  always_comb begin
    p_state_d    = p_state_q;
    dcnt_d       = dcnt_q;
    addr_d       = addr_q;
    data_d       = data_q;
    chk_d        = chk_q;
    param_addr_d = param_addr_q;
    param_data_d = param_data_q;
    param_we_d   = 1'b0;
    cmd_set      = 1'b0;
    tmo_d        = tmo_run ? tmo_q + TMO_W'(1) : '0;
    if (stop_bad) begin
      p_state_d = P_HDR;
    end else if (byte_valid_q) begin
      case (p_state_q)
        P_HDR: begin
          if (byte_q == 8'hA5) p_state_d = P_ADDR;
        end
        P_ADDR: begin
          if (byte_q[7:4] != 4'd0) begin
            cmd_set   = 1'b1;
            p_state_d = P_HDR;
          end else begin
            addr_d    = byte_q[3:0];
            chk_d     = byte_q;
            dcnt_d    = 2'd0;
            p_state_d = P_DATA;
          end
        end
        P_DATA: begin
          data_d = {data_q[23:0], byte_q};
          chk_d  = chk_q ^ byte_q;
          dcnt_d = dcnt_q + 2'd1;
          if (dcnt_q == 2'd3) p_state_d = P_CHK;
        end
        default: begin
          p_state_d = P_HDR;
          if (byte_q == chk_q) begin
            param_we_d   = 1'b1;
            param_addr_d = addr_q;
            param_data_d = data_q;
          end else begin
            cmd_set = 1'b1;
          end
        end
      endcase
    end else if (tmo_run && tmo_q == TMO_M1) begin
      cmd_set   = 1'b1;
      p_state_d = P_HDR;
    end
    frame_err_d = err_clr ? 1'b0 : (frame_err_q | frame_set);
    cmd_err_d   = err_clr ? 1'b0 : (cmd_err_q | cmd_set);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      u_state_q    <= U_IDLE;
      clk_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      byte_q       <= '0;
      p_state_q    <= P_HDR;
      dcnt_q       <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      chk_q        <= '0;
      tmo_q        <= '0;
      param_addr_q <= '0;
      param_data_q <= '0;
      param_we_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      cmd_err_q    <= 1'b0;
    end else begin
      rx_meta_q    <= RS232_Rx;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      u_state_q    <= u_state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      byte_q       <= byte_d;
      p_state_q    <= p_state_d;
      dcnt_q       <= dcnt_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      chk_q        <= chk_d;
      tmo_q        <= tmo_d;
      param_addr_q <= param_addr_d;
      param_data_q <= param_data_d;
      param_we_q   <= param_we_d;
      frame_err_q  <= frame_err_d;
      cmd_err_q    <= cmd_err_d;
    end
  end

  assign param_addr  = param_addr_q;
  assign param_data  = param_data_q;
  assign param_we    = param_we_q;
  assign frame_err   = frame_err_q;
  assign cmd_err     = cmd_err_q;
  assign dbg_state_o = {u_state_q, p_state_q};

endmodule

// File: doc/serial_param_rx.md
# serial_param_rx

Serial command receiver that sits directly upstream of the pulse generator core. Samples the RS232 receive line, deserialises 8N1 bytes, and parses fixed 7-byte parameter packets. Emits one-cycle register-write strobes (address + 32-bit value) that the pulse generator uses to load its period, width and delay registers. Malformed bytes or packets are discarded; each discard raises a sticky error flag.

## Interface
- CLKS_PER_BIT, 50, clk cycles per UART bit; minimum 8.
- TIMEOUT_BITS, 256, idle bit-times allowed between bytes of one packet before the parser aborts.
- clk  input  1  system clock; all logic on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- RS232_Rx  input  1  asynchronous serial line; idles high.
- param_addr  output  4  register address of the last accepted packet.
- param_data  output  32  register value of the last accepted packet.
- param_we  output  1  one-cycle write strobe qualifying param_addr/param_data.
- frame_err  output  1  sticky; set on a bad stop bit or a false start.
- cmd_err  output  1  sticky; set on bad address byte, bad checksum, or inter-byte timeout.
- err_clr  input  1  synchronous clear of frame_err and cmd_err.

## Operation
- RS232_Rx passes through a 2-flop synchroniser; its reset value is 1. All decoding uses the synchronised signal.
- UART FSM states: IDLE, START, DATA, STOP.
  - IDLE→START on a synchronised high→low transition.
  - In START, sample at CLKS_PER_BIT/2 (integer division). If the sample is high, this is a false start: set frame_err and go to IDLE. Otherwise go to DATA.
  - In DATA, sample 8 bits, LSB first, each CLKS_PER_BIT after the previous sample.
  - In STOP, sample once more. If the sample is 1, pulse the internal byte_valid. If it is 0, set frame_err, discard the byte, and reset the packet parser to HDR.
  - After STOP the FSM always returns to IDLE. A new start edge is accepted immediately, with no extra idle time required.
- Packet format: 0xA5, ADDR, D3, D2, D1, D0, CHK. Data is sent MSB first.
  - ADDR[7:4] must be 0.
  - CHK = ADDR ^ D3 ^ D2 ^ D1 ^ D0.
- Parser states: HDR, ADDR, DATA (4-byte counter), CHK.
  - In HDR, bytes other than 0xA5 are silently ignored; no error.
  - If ADDR[7:4] ≠ 0: set cmd_err, return to HDR.
  - If CHK mismatches: set cmd_err, return to HDR, no write.
  - If CHK matches: load param_addr/param_data and pulse param_we; return to HDR.
- Timeout:
  - Counts clk cycles while the parser is not in HDR and no byte is in progress.
  - Reaching TIMEOUT_BITS*CLKS_PER_BIT sets cmd_err and returns the parser to HDR.
  - The counter clears on every start edge.
- param_addr/param_data hold their values between writes; they are never updated by rejected packets.
- err_clr has priority over a simultaneous set: the flag reads 0 on the next cycle.
- Reset mid-byte or mid-packet drops all partial state; no write occurs.

## Timing
- Reset values:
  - param_addr = 0, param_data = 0, param_we = 0, frame_err = 0, cmd_err = 0.
  - Both FSMs in their idle states; synchroniser = 1.
- Input latency: 2 clk from the RS232_Rx pin to the synchronised signal.
- param_we goes high exactly 2 clk edges after the edge that samples the CHK byte's stop bit:
  - edge +1: byte_valid;
  - edge +2: registered write.
- param_addr/param_data are valid in the same cycle as param_we and remain stable afterwards.
- param_we is never high for two consecutive cycles. Minimum spacing between strobes is 70 bit-times.
- Sampling tolerates ±3% baud mismatch when CLKS_PER_BIT ≥ 16.

## Test plan
- Valid packet: send A5 03 00 00 12 34 25 at CLKS_PER_BIT=50 → one param_we pulse with param_addr=0x3, param_data=0x00001234; no error flags.
- Bad checksum: same packet with CHK=0x24 → no param_we; cmd_err=1; param_data stays at its prior value. Then assert err_clr → cmd_err=0.
- Framing error: drive stop bit low on the D1 byte → frame_err=1, packet discarded. A following valid packet (A5 01 DE AD BE EF 23) writes addr 0x1, data 0xDEADBEEF.
- Resync and false start: send noise bytes 00 FF A4, then a 10-cycle low glitch, then a valid packet → frame_err=1 from the glitch only; exactly one correct write.
- Timeout: send A5 02 11, then hold the line idle for 256 bit-times → cmd_err=1. A fresh valid packet is then accepted.
- Reset mid-packet: pull resetn low after the D2 byte, release, finish the packet's remaining bytes → no write, all outputs at reset values; the next full packet is accepted.
